// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared register-file constants and address type
package register_bank_pkg;
  localparam int REG_COUNT = 16;
  localparam int ADDR_W = 4;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t PC_INDEX = 4'd15;
endpackage

// File: rtl/register_bank_read_port.sv
// register_bank_read_port: combinational read mux (regs: R0-R14, pc: R15, addr -> data)
module register_bank_read_port
  import register_bank_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [REG_COUNT-2:0][N-1:0] regs,
  input  logic [N-1:0]                pc,
  input  reg_addr_t                   addr,
  output logic [N-1:0]                data
);
  assign data = (addr == PC_INDEX) ? pc : regs[addr];
endmodule

// File: rtl/register_bank.sv
// register_bank: 16-entry ARM-style register file (R15=pc) plus cspr; 4 comb read ports, 2 write ports, pc/cspr load ports
module register_bank
  import register_bank_pkg::*;
#(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  reg_addr_t       in_address1,
  input  reg_addr_t       in_address2,
  input  reg_addr_t       in_address3,
  input  reg_addr_t       in_address4,
  output logic [N-1:0]    out_data1,
  output logic [N-1:0]    out_data2,
  output logic [N-1:0]    out_data3,
  output logic [N-1:0]    out_data4,
  input  reg_addr_t       write_address,
  input  logic [N-1:0]    write_data,
  input  logic            write_enable,
  input  reg_addr_t       write_address2,
  input  logic [N-1:0]    write_data2,
  input  logic            write_enable2,
  output logic [N-1:0]    pc,
  input  logic [N-1:0]    pc_update,
  input  logic            pc_write,
  output logic [N-1:0]    cspr,
  input  logic [N-1:0]    cspr_update,
  input  logic            cspr_write
);
  logic [REG_COUNT-2:0][N-1:0] regs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      pc   <= '0;
      cspr <= '0;
    end else begin
      if (write_enable && write_address != PC_INDEX) regs[write_address] <= write_data;
      if (write_enable2 && write_address2 != PC_INDEX) regs[write_address2] <= write_data2;
      if (pc_write) pc <= pc_update;
      if (cspr_write) cspr <= cspr_update;
    end
  end
  register_bank_read_port #(.N(N)) u_rd1 (.regs(regs), .pc(pc), .addr(in_address1), .data(out_data1));
  register_bank_read_port #(.N(N)) u_rd2 (.regs(regs), .pc(pc), .addr(in_address2), .data(out_data2));
  register_bank_read_port #(.N(N)) u_rd3 (.regs(regs), .pc(pc), .addr(in_address3), .data(out_data3));
  register_bank_read_port #(.N(N)) u_rd4 (.regs(regs), .pc(pc), .addr(in_address4), .data(out_data4));
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: scoreboard bench for register_bank
module tb_register_bank;
  logic clk = 0;
  logic rst_n;
  logic [3:0] a1, a2, a3, a4, wa, wa2;
  logic [31:0] d1, d2, d3, d4, wd, wd2, pc, pc_upd, cspr, cspr_upd;
  logic we, we2, pc_wr, cspr_wr;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  event chk;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  register_bank #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_address1(a1), .in_address2(a2), .in_address3(a3), .in_address4(a4),
    .out_data1(d1), .out_data2(d2), .out_data3(d3), .out_data4(d4),
    .write_address(wa), .write_data(wd), .write_enable(we),
    .write_address2(wa2), .write_data2(wd2), .write_enable2(we2),
    .pc(pc), .pc_update(pc_upd), .pc_write(pc_wr),
    .cspr(cspr), .cspr_update(cspr_upd), .cspr_write(cspr_wr)
  );
  function automatic logic [31:0] obs(input int s);
    return s == 0 ? d1 : s == 1 ? d2 : s == 2 ? d3 : s == 3 ? d4 : s == 4 ? pc : cspr;
  endfunction
  initial forever begin
    @(chk);
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = sb.pop_front();
      got = obs(e.sel);
      n_chk++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end
  task automatic expect_v(input string n, input int s, input logic [31:0] v);
    sb.push_back('{n, s, v});
  endtask
  task automatic check_now();
    ->chk;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    we = 0; we2 = 0; pc_wr = 0; cspr_wr = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0; idle();
    a1 = 0; a2 = 0; a3 = 0; a4 = 0; wa = 0; wa2 = 0; wd = 0; wd2 = 0; pc_upd = 0; cspr_upd = 0;
    #2;
    expect_v("reset_d1", 0, 0); expect_v("reset_pc", 4, 0); expect_v("reset_cspr", 5, 0);
    check_now();
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    wa = 1; wd = 32'h55; we = 1; pc_upd = 32'h33; pc_wr = 1; cspr_upd = 32'h44; cspr_wr = 1; a1 = 1;
    tick();
    expect_v("preload_r1", 0, 32'h55); expect_v("preload_pc", 4, 32'h33); expect_v("preload_cspr", 5, 32'h44);
    check_now();
    @(negedge clk);
    wd = 32'h99; pc_upd = 32'h999; cspr_upd = 32'h444;
    #2 rst_n = 0;
    #1;
    expect_v("async_rst_r1", 0, 0); expect_v("async_rst_pc", 4, 0); expect_v("async_rst_cspr", 5, 0);
    check_now();
    tick();
    expect_v("rst_edge_r1", 0, 0); expect_v("rst_edge_pc", 4, 0); expect_v("rst_edge_cspr", 5, 0);
    check_now();
    @(negedge clk); idle(); rst_n = 1;
    tick();
    expect_v("post_rst_r1", 0, 0); expect_v("post_rst_pc", 4, 0);
    check_now();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      wa = 4'(k); wd = 32'(10 + k); we = 1; a1 = 4'(k);
      tick();
      expect_v($sformatf("fill_r%0d", k), 0, 32'(10 + k));
      check_now();
    end
    @(negedge clk); idle();
    a1 = 0; a2 = 5; a3 = 10; a4 = 14;
    #1;
    expect_v("fill_p1_r0", 0, 10); expect_v("fill_p2_r5", 1, 15);
    expect_v("fill_p3_r10", 2, 20); expect_v("fill_p4_r14", 3, 24);
    check_now();
    @(negedge clk);
    wa = 3; wd = 32'hAAAA_AAAA; we = 1; wa2 = 7; wd2 = 32'h5555_5555; we2 = 1; a1 = 3; a2 = 7;
    tick();
    expect_v("dual_r3", 0, 32'hAAAA_AAAA); expect_v("dual_r7", 1, 32'h5555_5555);
    check_now();
    @(negedge clk);
    wa = 4; wd = 1; wa2 = 4; wd2 = 2; a3 = 4;
    tick();
    expect_v("collide_r4", 2, 2);
    check_now();
    @(negedge clk); idle();
    pc_upd = 32'h100; pc_wr = 1; a4 = 15;
    tick();
    expect_v("pc_load", 4, 32'h100); expect_v("pc_read15", 3, 32'h100);
    check_now();
    @(negedge clk); idle();
    wa = 15; wd = 32'hDEAD; we = 1; wa2 = 15; wd2 = 32'hBEEF; we2 = 1; a1 = 14;
    tick();
    expect_v("pc_protect", 4, 32'h100); expect_v("pc_protect_rd", 3, 32'h100); expect_v("r14_untouched", 0, 24);
    check_now();
    @(negedge clk); idle();
    cspr_upd = 32'hF000_0000; cspr_wr = 1;
    tick();
    expect_v("cspr_load", 5, 32'hF000_0000);
    check_now();
    @(negedge clk); idle(); cspr_upd = 32'h1234_5678;
    tick();
    expect_v("cspr_hold", 5, 32'hF000_0000);
    check_now();
    @(negedge clk);
    wa = 2; wd = 32'h1234; we = 1; a1 = 2;
    #1;
    expect_v("nobypass_pre", 0, 32'h0C);
    check_now();
    tick();
    expect_v("nobypass_post", 0, 32'h1234);
    check_now();
    @(negedge clk); idle();
    wa = 5; wd = 32'h11; we = 1; wa2 = 6; wd2 = 32'h22; we2 = 1;
    pc_upd = 32'h200; pc_wr = 1; cspr_upd = 32'hA5; cspr_wr = 1; a1 = 5; a2 = 6;
    tick();
    expect_v("all_r5", 0, 32'h11); expect_v("all_r6", 1, 32'h22);
    expect_v("all_pc", 4, 32'h200); expect_v("all_cspr", 5, 32'hA5);
    check_now();
    @(negedge clk); idle();
    wd = 32'hFFFF_FFFF; wd2 = 32'hFFFF_FFFF; pc_upd = 32'h7; cspr_upd = 32'h7;
    a1 = 2; a2 = 3; a3 = 4; a4 = 15;
    repeat (5) tick();
    expect_v("hold_r2", 0, 32'h1234); expect_v("hold_r3", 1, 32'hAAAA_AAAA);
    expect_v("hold_r4", 2, 2); expect_v("hold_r15", 3, 32'h200);
    expect_v("hold_pc", 4, 32'h200); expect_v("hold_cspr", 5, 32'hA5);
    check_now();
    #5;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/register_bank.md
# register_bank

ARM-style general-purpose register file for the RVKP-1 pipeline core. It holds 16 architectural registers: R0–R14 are general storage and R15 is the program counter. A separate CPSR status register sits alongside them. The decode stage reads up to four operands per cycle. Writeback and PC/flag update logic write results on the clock edge.

## Interface
- `N`, default 32: data width of every register, PC and CPSR.

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_address1`..`in_address4`  in  4 each  read addresses for the four read ports
- `out_data1`..`out_data4`  out  N each  read data for the matching address
- `write_address`  in  4  write port 1 address
- `write_data`  in  N  write port 1 data
- `write_enable`  in  1  write port 1 enable
- `write_address2`  in  4  write port 2 address
- `write_data2`  in  N  write port 2 data
- `write_enable2`  in  1  write port 2 enable
- `pc`  out  N  current PC (R15) value
- `pc_update`  in  N  next PC value
- `pc_write`  in  1  PC load enable
- `cspr`  out  N  current status register
- `cspr_update`  in  N  next status value
- `cspr_write`  in  1  status load enable

## Operation
- **Storage:** 15 × N general registers R0–R14, plus the PC register (R15) and the CPSR register.
- **Reads:** combinational and fully independent on all four ports. Address 0–14 returns the stored register; address 15 returns the current `pc`. There is no write-to-read bypass: a value written at an edge appears on the outputs only after that edge.
- **Write ports 1 and 2:** when the enable is high, store the port's data into the addressed register (addresses 0–14).
  - Writes to address 15 through either port are ignored.
  - If both ports are enabled with the same address, port 2 wins.
  - If the addresses differ, both writes take effect in the same cycle.
- **PC:** loads `pc_update` when `pc_write=1`; otherwise holds. Only `pc_write` alters the PC.
- **CPSR:** loads `cspr_update` when `cspr_write=1`; otherwise holds. The full N bits are stored; the block does not interpret flag bits.
- **Outputs:** `pc` and `cspr` are the register contents directly (no combinational path from the update inputs).
- Values are not modified: no sign or width conversion, and no PC offset (+8) is applied inside this block.

## Timing
- **Reset:** `rst_n` low clears R0–R14, the PC and the CPSR to 0 immediately, without waiting for a clock edge.
  - Consequences: `out_data*=0`, `pc=0` and `cspr=0` while reset is asserted.
  - Reset overrides every enable, including enables asserted in the same cycle reset is released.
- **Write latency:** 1 cycle. Data presented before rising edge k is readable from that edge onward, after combinational delay only.
- **Read latency:** 0 cycles, purely combinational from address to data.
- **Simultaneous events:** a same-edge read of the register being written returns the old value until the edge. `pc_write`, `cspr_write` and both port writes may all occur in the same cycle without interference.
- **Idle:** all enables low ⇒ state is held indefinitely.

## Structure
- **Shared package `register_bank_pkg`:**
  - `REG_COUNT=16`
  - `ADDR_W=4`
  - `PC_INDEX=4'd15`
  - typedef `reg_addr_t` (logic [3:0])
- **Sub-module `register_bank_read_port`:** combinational mux from the register array plus PC by a 4-bit address. Instantiate it four times.
- The write logic and the PC/CPSR registers stay in the top module.

## Test plan
- **Reset:**
  - Stimulus: pulse `rst_n` low mid-cycle with `write_enable=1`.
  - Required: all outputs are 0 immediately; no write occurs during reset.
- **Sequential fill:**
  - Stimulus: on successive cycles, write `10+k` to Rk for k=0..14 via port 1. After each edge, read Rk on `in_address1`.
  - Required: returns `10+k`. After the fill, ports 1–4 read R0, R5, R10, R14 = 10, 15, 20, 24.
- **Dual write:**
  - Stimulus: same cycle, port 1 writes R3=0xAAAA_AAAA and port 2 writes R7=0x5555_5555.
  - Required: both are readable next cycle.
  - Stimulus: both ports write R4 with 1 and 2 respectively.
  - Required: R4=2.
- **PC behaviour:**
  - Stimulus: `pc_write=1`, `pc_update=0x100`.
  - Required: `pc=0x100` after the edge, and reading address 15 returns 0x100.
  - Stimulus: port 1 writes address 15 with 0xDEAD.
  - Required: `pc` remains 0x100.
- **CPSR:**
  - Stimulus: `cspr_write=1`, `cspr_update=0xF000_0000`.
  - Required: `cspr=0xF000_0000`; the value is held when `cspr_write=0` and `cspr_update` changes.
- **No bypass / hold:**
  - Stimulus: write R2=0x1234 while reading R2 (old value 0x0C).
  - Required: output is 0x0C before the edge and 0x1234 after.
  - Stimulus: enables low for 5 cycles.
  - Required: all values unchanged.
